// File: rtl/mem_sched_pkg.sv
// Shared types and widths for the IF/MEM single-port RAM access scheduler.
package mem_sched_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_sched_starve_ctr.sv
// Counts MEM grants that bypassed a waiting IF request; saturates at max.
module mem_sched_starve_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  input  logic [2:0] max,
  output logic [2:0] count,
  output logic       at_max
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 3'd0;
    end else if (clr) begin
      count <= 3'd0;
    end else if (inc && (count < max)) begin
      count <= count + 3'd1;
    end
  end

  assign at_max = (count >= max);
endmodule

// File: rtl/mem_access_sched.sv
// Arbitrates IF fetches and MEM loads/stores onto one synchronous single-port RAM,
// with MEM priority bounded by a starvation limit for IF.
module mem_access_sched
  import mem_sched_pkg::*;
#(
  parameter int MEM_WAIT   = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              granted_to_if,
  output logic              granted_to_mem,
  output logic              stall_if,
  output logic              stall_mem
);
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              lat_we;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] mem_rdata_reg;
  logic [2:0]        starve_count;
  logic              starve_at_max;
  logic              grant_if;
  logic              grant_mem;

  assign grant_if  = (state == ST_IDLE) && if_req &&
                     (!mem_req || (starve_count == STARVE_LIM));
  assign grant_mem = (state == ST_IDLE) && mem_req && !grant_if;

  mem_sched_starve_ctr u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (grant_mem && if_req && !starve_at_max),
    .clr    (grant_if),
    .max    (STARVE_LIM),
    .count  (starve_count),
    .at_max (starve_at_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      wait_cnt       <= 4'd0;
      lat_we         <= 1'b0;
      granted_to_if  <= 1'b0;
      granted_to_mem <= 1'b0;
      ram_en         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      if_ack         <= 1'b0;
      mem_ack        <= 1'b0;
      if_rdata_reg   <= '0;
      mem_rdata_reg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wait_cnt <= 4'd0;
          if (grant_if) begin
            granted_to_if <= 1'b1;
            lat_we        <= 1'b0;
            ram_en        <= 1'b1;
            ram_we        <= 1'b0;
            ram_addr      <= if_addr;
            ram_wdata     <= '0;
            state         <= ST_ACCESS;
          end else if (grant_mem) begin
            granted_to_mem <= 1'b1;
            lat_we         <= mem_we;
            ram_en         <= 1'b1;
            ram_we         <= mem_we;
            ram_addr       <= mem_addr;
            ram_wdata      <= mem_wdata;
            state          <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt == WAIT_LAST) begin
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            if_ack  <= granted_to_if;
            mem_ack <= granted_to_mem;
            state   <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          // RAM data only appears during RESP, so the held copy is taken as RESP ends.
          if (!lat_we && granted_to_if)  if_rdata_reg  <= ram_rdata;
          if (!lat_we && granted_to_mem) mem_rdata_reg <= ram_rdata;
          if_ack         <= 1'b0;
          mem_ack        <= 1'b0;
          granted_to_if  <= 1'b0;
          granted_to_mem <= 1'b0;
          wait_cnt       <= 4'd0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign if_rdata  = (if_ack && !lat_we) ? ram_rdata : if_rdata_reg;
  assign mem_rdata = (mem_ack && !lat_we) ? ram_rdata : mem_rdata_reg;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;
endmodule
